gtech_fd14_rr_arb: RTL and testbench
====================================

# gtech_fd14_rr_arb

Round-robin write arbiter and sequencer for a 4-bit four-flop register bank. Up to four requesters compete to load a word into the bank. The bank drives a single downstream consumer through a valid/ready handshake. The block contains the bank itself, the grant logic, the rotating priority pointer and a two-state occupancy FSM. It is used wherever several producers share one GTECH-style 4-bit holding register.

## Interface
Parameters:
- NREQ, 4, number of requesters; fixed at 4, and other values are unsupported.
- WIDTH, 4, data width per requester; equals the bank width of 4 lanes.

Ports:
- CP  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset; sampled on the rising edge of CP.
- REQ  input  4  per-requester request; bit i belongs to requester i.
- DIN  input  16  requester data; DIN[4i+3:4i] belongs to requester i.
- LOCK  input  4  per-requester grant lock; used only when GTECH_ARB_LOCK_EN is defined.
- GNT  output  4  one-hot grant, combinational; at most one bit is high.
- Q  output  4  bank contents (lanes Q0..Q3 map to Q[0]..Q[3]).
- QN  output  4  ~Q.
- OVALID  output  1  bank holds a word not yet accepted downstream.
- ORDY  input  1  downstream accepts the word.
- OSRC  output  2  index of the requester whose word is in the bank.

## Operation
- FSM states:
  - EMPTY (OVALID=0).
  - FULL (OVALID=1).
- Space available: `space = ~OVALID | ORDY`.
- Grant: GNT[i]=1 when all of the following hold:
  - RST=0;
  - space=1;
  - REQ[i]=1;
  - i is the first requesting index found scanning i = ptr, ptr+1, … mod 4.
- Transfer on grant to i, at the next edge:
  - Q ← DIN[4i+3:4i];
  - OSRC ← i;
  - FSM → FULL;
  - ptr ← (i+1) mod 4.
- FULL and ORDY=1 with no grant: FSM → EMPTY; Q and OSRC hold their values.
- FULL and ORDY=1 with a grant in the same cycle: the new word replaces the old one and OVALID stays 1. This gives back-to-back throughput of one word per cycle.
- FULL and ORDY=0: GNT=0; Q, OSRC and ptr hold.
- No REQ bits high: GNT=0; ptr holds.
- Requester protocol:
  - keep REQ[i] high and DIN stable until the cycle GNT[i]=1;
  - deassert REQ[i] in the following cycle unless another word is to be sent.
- QN is always the bitwise inverse of Q, including during reset.
- Reset values: Q=0000, QN=1111, OVALID=0, OSRC=00, ptr=0, FSM=EMPTY, GNT=0000.
- Reset mid-transfer: a word held in FULL is discarded. No grant is issued while RST=1, regardless of ORDY.

## Timing
- Latency: REQ→GNT is 0 cycles (combinational). GNT→Q/OVALID is 1 cycle.
- Sustained throughput is 1 word/cycle with ORDY tied high.
- Fairness: with all four REQ bits held high, the grant order is 0,1,2,3,0,… Any continuously requesting requester waits at most 3 grants.
- The handshake completes on any CP edge where OVALID=1 and ORDY=1.
- ORDY may depend combinationally on OVALID. GNT depends combinationally on ORDY, REQ and LOCK. There is no path from GNT back to ORDY.

## Configuration
- Macro: GTECH_ARB_LOCK_EN.
- With the macro defined:
  - if the last grant went to requester k, and LOCK[k]=1 and REQ[k]=1, requester k is granted ahead of the rotation;
  - ptr is not advanced while a lock is in effect;
  - the lock releases the first cycle LOCK[k]=0 or REQ[k]=0, and normal rotation resumes from ptr=(k+1) mod 4.
- With the macro undefined: the LOCK input is ignored and arbitration is pure round-robin.

## Test plan
- Reset: set RST=1 for 2 cycles with REQ=1111 and ORDY=1. Required: GNT=0000, Q=0000, QN=1111, OVALID=0, OSRC=00. After release, the first grant is GNT=0001.
- Rotation: REQ=1111, ORDY=1, DIN lanes 0..3 = 4'hA, 4'hB, 4'hC, 4'hD. Required:
  - GNT sequence 0001, 0010, 0100, 1000, 0001;
  - Q follows A, B, C, D one cycle after each grant;
  - OSRC = 0, 1, 2, 3.
- Backpressure: load 4'h5 from requester 2, then ORDY=0 for 3 cycles with REQ=1011. Required:
  - GNT=0000 during the stall;
  - Q=0101 and OSRC=10 held;
  - when ORDY=1, GNT=1000 (ptr=3) and Q updates the next cycle with OVALID remaining 1.
- Drain: OVALID=1, REQ=0000, ORDY=1. Required: OVALID=0 next cycle with Q unchanged. A later REQ=0100 gives GNT=0100 immediately.
- Reset mid-operation: OVALID=1 with Q=4'hF, assert RST for 1 cycle. Required: Q=0000, OVALID=0, ptr=0. The next grant with REQ=1100 goes to requester 2.
- Lock (GTECH_ARB_LOCK_EN defined): REQ=0011, LOCK=0001, ORDY=1. Required:
  - GNT=0001 for as long as LOCK[0]=1;
  - after LOCK drops, GNT=0010.

  Without the macro, the same stimulus alternates 0001 and 0010.

Source files
------------

// File: rtl/gtech_fd14_rr_arb_if.sv
// Requester/consumer bundle for the gtech_fd14_rr_arb holding-register arbiter.
// master: drives requests, data, locks and downstream ready.
// slave:  the arbiter itself.
interface gtech_fd14_rr_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] DIN;
    logic [NREQ-1:0]       LOCK;
    logic [NREQ-1:0]       GNT;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      QN;
    logic                  OVALID;
    logic                  ORDY;
    logic [1:0]            OSRC;

    modport master (
        output REQ, DIN, LOCK, ORDY,
        input  GNT, Q, QN, OVALID, OSRC
    );

    modport slave (
        input  REQ, DIN, LOCK, ORDY,
        output GNT, Q, QN, OVALID, OSRC
    );
endinterface

// File: rtl/gtech_fd14_rr_arb.sv
// Round-robin write arbiter feeding a 4-bit four-flop holding register that
// drives one downstream consumer over a valid/ready handshake.
// Optional macro GTECH_ARB_LOCK_EN: lets the last-granted requester keep the
// grant while it holds LOCK and REQ; otherwise LOCK is ignored.
module gtech_fd14_rr_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input logic                  CP,
    input logic                  RST,
    gtech_fd14_rr_arb_if.slave   bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ptr;
    logic [WIDTH-1:0] q;
    logic [1:0]       osrc;

    logic             space;
    logic             rr_hit;
    logic [1:0]       rr_idx;
    logic             lock_hit;
    logic             sel_hit;
    logic [1:0]       sel_idx;
    logic             gnt_any;
    logic [NREQ-1:0]  gnt;

    assign space = (state == EMPTY) | bus.ORDY;

    // Rotating scan: first requester at or after ptr (lowest offset wins).
    always_comb begin
        logic [1:0] idx;
        rr_hit = 1'b0;
        rr_idx = ptr;
        idx    = ptr;
        for (int j = NREQ - 1; j >= 0; j--) begin
            idx = ptr + 2'(j);
            if (bus.REQ[idx]) begin
                rr_hit = 1'b1;
                rr_idx = idx;
            end
        end
    end

`ifdef GTECH_ARB_LOCK_EN
    // OSRC is the last granted requester, but only once a grant has happened
    // since reset; last_vld keeps the reset value of OSRC from acting as a lock.
    logic last_vld;

    // Lock holds the grant on the previous winner while it keeps LOCK and REQ.
    always_comb begin
        lock_hit = last_vld & bus.LOCK[osrc] & bus.REQ[osrc];
    end

    // Tracks whether OSRC names a real previous grant.
    always_ff @(posedge CP) begin
        if (RST) begin
            last_vld <= 1'b0;
        end else if (gnt_any) begin
            last_vld <= 1'b1;
        end
    end
`else
    logic [NREQ-1:0] lock_unused;
    assign lock_unused = bus.LOCK;

    // Pure round-robin: no lock override.
    always_comb begin
        lock_hit = 1'b0;
    end
`endif

    // Final grant: lock override first, then rotation; suppressed by reset or no space.
    always_comb begin
        sel_hit = lock_hit | rr_hit;
        sel_idx = lock_hit ? osrc : rr_idx;
        gnt_any = ~RST & space & sel_hit;
        gnt     = '0;
        if (gnt_any) begin
            gnt = NREQ'(1) << sel_idx;
        end
    end

    // Occupancy next-state: a grant always fills; an accepted word with no grant empties.
    always_comb begin
        state_nxt = state;
        if (gnt_any) begin
            state_nxt = FULL;
        end else if (state == FULL && bus.ORDY) begin
            state_nxt = EMPTY;
        end
    end

    // Occupancy state register.
    always_ff @(posedge CP) begin
        if (RST) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority pointer moves past the winner, but stays put while a lock holds.
    always_ff @(posedge CP) begin
        if (RST) begin
            ptr <= 2'd0;
        end else if (gnt_any && !lock_hit) begin
            ptr <= sel_idx + 2'd1;
        end
    end

    // Holding register and source tag load on every grant.
    always_ff @(posedge CP) begin
        if (RST) begin
            q    <= '0;
            osrc <= 2'd0;
        end else if (gnt_any) begin
            q    <= bus.DIN[sel_idx*WIDTH +: WIDTH];
            osrc <= sel_idx;
        end
    end

    assign bus.GNT    = gnt;
    assign bus.Q      = q;
    assign bus.QN     = ~q;
    assign bus.OVALID = (state == FULL);
    assign bus.OSRC   = osrc;
endmodule

// File: tb/tb_gtech_fd14_rr_arb.sv
// Directed bench for gtech_fd14_rr_arb: reset, rotation, backpressure, drain,
// reset mid-operation and lock behaviour (both macro settings).
module tb_gtech_fd14_rr_arb;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    gtech_fd14_rr_arb_if bus ();

    gtech_fd14_rr_arb dut (
        .CP  (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int i, input logic [3:0] v);
        bus.DIN[i*4 +: 4] = v;
    endtask

    initial begin
        rst      = 1'b1;
        bus.REQ  = 4'b1111;
        bus.ORDY = 1'b1;
        bus.LOCK = 4'b0000;
        bus.DIN  = 16'hDCBA;

        // Reset held two cycles with all requests and ready high.
        tick();
        settle();
        chk("rst_gnt_c1", bus.GNT, 4'b0000);
        tick();
        settle();
        chk("rst_gnt", bus.GNT, 4'b0000);
        chk("rst_q", bus.Q, 4'h0);
        chk("rst_qn", bus.QN, 4'hF);
        chk("rst_ovalid", bus.OVALID, 1'b0);
        chk("rst_osrc", bus.OSRC, 2'd0);

        // Rotation 0,1,2,3,0 with A..D on lanes 0..3.
        rst = 1'b0;
        settle();
        chk("rot_gnt0", bus.GNT, 4'b0001);
        tick();
        chk("rot_q0", bus.Q, 4'hA);
        chk("rot_osrc0", bus.OSRC, 2'd0);
        chk("rot_ov0", bus.OVALID, 1'b1);
        chk("rot_gnt1", bus.GNT, 4'b0010);
        tick();
        chk("rot_q1", bus.Q, 4'hB);
        chk("rot_osrc1", bus.OSRC, 2'd1);
        chk("rot_gnt2", bus.GNT, 4'b0100);
        tick();
        chk("rot_q2", bus.Q, 4'hC);
        chk("rot_osrc2", bus.OSRC, 2'd2);
        chk("rot_gnt3", bus.GNT, 4'b1000);
        tick();
        chk("rot_q3", bus.Q, 4'hD);
        chk("rot_osrc3", bus.OSRC, 2'd3);
        chk("rot_qn3", bus.QN, 4'h2);
        chk("rot_gnt4", bus.GNT, 4'b0001);

        // Backpressure: load 5 from requester 2, then stall three cycles.
        bus.REQ = 4'b0100;
        set_lane(2, 4'h5);
        settle();
        chk("bp_load_gnt", bus.GNT, 4'b0100);
        tick();
        chk("bp_load_q", bus.Q, 4'h5);
        chk("bp_load_osrc", bus.OSRC, 2'd2);
        bus.ORDY = 1'b0;
        bus.REQ  = 4'b1011;
        set_lane(3, 4'h7);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("bp_stall_gnt", bus.GNT, 4'b0000);
            tick();
            chk("bp_stall_q", bus.Q, 4'h5);
            chk("bp_stall_osrc", bus.OSRC, 2'd2);
            chk("bp_stall_ov", bus.OVALID, 1'b1);
        end
        bus.ORDY = 1'b1;
        settle();
        chk("bp_resume_gnt", bus.GNT, 4'b1000);
        tick();
        chk("bp_resume_q", bus.Q, 4'h7);
        chk("bp_resume_osrc", bus.OSRC, 2'd3);
        chk("bp_resume_ov", bus.OVALID, 1'b1);

        // Drain with no requests, then a lone request is granted at once.
        bus.REQ = 4'b0000;
        settle();
        chk("drain_gnt", bus.GNT, 4'b0000);
        tick();
        chk("drain_ov", bus.OVALID, 1'b0);
        chk("drain_q", bus.Q, 4'h7);
        bus.REQ = 4'b0100;
        set_lane(2, 4'hF);
        settle();
        chk("drain_req_gnt", bus.GNT, 4'b0100);
        tick();
        chk("drain_req_q", bus.Q, 4'hF);
        chk("drain_req_ov", bus.OVALID, 1'b1);

        // Reset mid-operation discards the held word and clears ptr.
        bus.REQ = 4'b0000;
        rst     = 1'b1;
        settle();
        chk("mrst_gnt", bus.GNT, 4'b0000);
        tick();
        chk("mrst_q", bus.Q, 4'h0);
        chk("mrst_qn", bus.QN, 4'hF);
        chk("mrst_ov", bus.OVALID, 1'b0);
        chk("mrst_osrc", bus.OSRC, 2'd0);
        rst     = 1'b0;
        bus.REQ = 4'b1100;
        set_lane(2, 4'h9);
        settle();
        chk("mrst_next_gnt", bus.GNT, 4'b0100);
        tick();
        chk("mrst_next_q", bus.Q, 4'h9);

        // Lock stimulus: REQ=0011, LOCK=0001 (ptr is 3 here, so 0 wins first).
        bus.REQ  = 4'b0011;
        bus.LOCK = 4'b0001;
        settle();
        chk("lock_gnt0", bus.GNT, 4'b0001);
        tick();
`ifdef GTECH_ARB_LOCK_EN
        chk("lock_gnt1", bus.GNT, 4'b0001);
        tick();
        chk("lock_gnt2", bus.GNT, 4'b0001);
        tick();
`else
        chk("lock_gnt1", bus.GNT, 4'b0010);
        tick();
        chk("lock_gnt2", bus.GNT, 4'b0001);
        tick();
`endif
        chk("lock_osrc", bus.OSRC, 2'd0);
        bus.LOCK = 4'b0000;
        settle();
        chk("lock_release_gnt", bus.GNT, 4'b0010);
        tick();
        chk("lock_release_osrc", bus.OSRC, 2'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
